layer6_result_buffer: RTL and testbench
=======================================

// Module: layer6_result_buffer
// PURPOSE
//  Frame store directly downstream of the layer-6 2x2 max-pooling stage. Captures each pooled
//  128-bit pixel (8 ch x 16 bit) at (output_row, output_col) when save_enable is high.
//  After a full OUT_W x OUT_W frame it pulses pixel_store_done for the next layer, then
//  serves random-access row/col reads with 1-cycle latency.
// PARAMETERS
//  DATA_W  128  pixel width (8 channels x 16 bit)
//  OUT_W   8    pooled frame width = height (pixels)
//  ADDR_W  16   row/col address width (WORDLENGTH)
// PORTS
//  clk              in   1       clock; all logic on rising edge
//  rst              in   1       synchronous, active-high reset
//  save_enable      in   1       write strobe from pooling stage
//  output_row       in   ADDR_W  write row (0..OUT_W-1)
//  output_col       in   ADDR_W  write col (0..OUT_W-1)
//  output_data      in   DATA_W  pooled pixel to store
//  layer6_calculation_done in 1  end-of-frame pulse from pooling stage
//  read_pixel_signal in  1       read request from next layer
//  read_row_addr    in   ADDR_W  read row
//  read_col_addr    in   ADDR_W  read col
//  read_data        out  DATA_W  registered read pixel
//  read_valid       out  1       high the cycle read_data is valid
//  pixel_store_done out  1       1-cycle pulse: frame complete, reads permitted
//  frame_error      out  1       sticky: calculation_done seen with frame incomplete
// BEHAVIOUR
//  Reset: state=IDLE, wr_count=0, read_data=0, read_valid=0, pixel_store_done=0,
//   frame_error=0. Memory contents not reset. rst mid-frame aborts fill; no done pulse.
//  FSM IDLE -> FILL on first save_enable; FILL -> DONE when wr_count reaches OUT_W*OUT_W
//   after the write; DONE (1 cycle, pixel_store_done=1) -> SERVE; SERVE -> FILL on save_enable
//   (new frame; that write counts as 1).
//  Write: mem[row*OUT_W+col] <= output_data in the save_enable cycle; wr_count++ only for
//   in-range addresses (row,col < OUT_W); out-of-range writes dropped, not counted.
//  Duplicate address writes overwrite and still count (pooling stage never repeats).
//  layer6_calculation_done in FILL with wr_count (incl. same-cycle write) < OUT_W*OUT_W:
//   frame_error<=1, state->IDLE, wr_count<=0. Same cycle as final write: normal DONE.
//  Read: read_pixel_signal in cycle N -> read_data/read_valid in N+1. Reads honoured in any
//   state (data meaningful only after done). Out-of-range address -> read_data=0.
//  Read and write same address same cycle: read returns OLD value (read-before-write).
//  read_valid=0 and read_data holds last value when no request.
//  Address math: index = row*OUT_W+col, width clog2(OUT_W*OUT_W); range check on full ADDR_W.
// CONFIGURATION
//  LAYER6_BUF_ZERO_PAD_EN defined: read addresses are padded coordinates, valid 0..OUT_W+1;
//   row/col==0 or ==OUT_W+1 return 0 (3x3 conv halo), else index=(row-1)*OUT_W+(col-1);
//   >OUT_W+1 returns 0. Undefined: unpadded reads as above. Write side unaffected.
// STRUCTURE
//  Package layer6_buf_pkg: DATA_W/OUT_W/ADDR_W defaults, FRAME_PIX=OUT_W*OUT_W,
//   IDX_W=$clog2(FRAME_PIX), typedef enum logic[1:0] {IDLE,FILL,DONE,SERVE} buf_state_t.
//  Sub-module buffer_mem: 1W1R synchronous RAM, DEPTH=FRAME_PIX, registered read port.
//  Top holds FSM, write counter, range check/padding decode, output regs.
// TESTING
//  1 Write all 64 pixels, data={8{row,col}} -> pixel_store_done one pulse 1 cycle after
//    64th write; read (3,5) -> read_valid next cycle, read_data={8{16'h0305}}.
//  2 Write 63 pixels then layer6_calculation_done -> frame_error=1, no done pulse, state IDLE.
//  3 Write to (8,0) -> ignored; frame needs 64 valid writes; read (8,0) -> 0.
//  4 Same-cycle write (2,2)=A over old B and read (2,2) -> read_data=B; next read -> A.
//  5 rst asserted after 30 writes, then full 64-write frame -> exactly one done pulse.
//  6 ZERO_PAD_EN: read (0,4) -> 0; read (1,1) -> pixel (0,0); read (9,9) -> 0.

Source files
------------

// File: rtl/layer6_buf_pkg.sv
// Shared sizing, state encoding and address helpers for the layer-6 result buffer.
package layer6_buf_pkg;

    localparam int DATA_W    = 128;
    localparam int OUT_W     = 8;
    localparam int ADDR_W    = 16;
    localparam int FRAME_PIX = OUT_W * OUT_W;
    localparam int IDX_W     = $clog2(FRAME_PIX);
    localparam int CNT_W     = $clog2(FRAME_PIX + 1);

    typedef enum logic [1:0] {IDLE, FILL, DONE, SERVE} buf_state_t;

    // Range check is done on the full address width so high bits cannot alias into the frame.
    function automatic logic in_frame(input logic [ADDR_W-1:0] row, input logic [ADDR_W-1:0] col);
        return (row < ADDR_W'(OUT_W)) && (col < ADDR_W'(OUT_W));
    endfunction

    function automatic logic [IDX_W-1:0] pix_idx(input logic [ADDR_W-1:0] row,
                                                 input logic [ADDR_W-1:0] col);
        return IDX_W'(row * ADDR_W'(OUT_W) + col);
    endfunction

endpackage

// File: rtl/layer6_result_buffer_if.sv
// Pooling-stage write port, next-layer read port and frame status of the layer-6 result buffer.
interface layer6_result_buffer_if;
    import layer6_buf_pkg::*;

    logic              save_enable;
    logic [ADDR_W-1:0] output_row;
    logic [ADDR_W-1:0] output_col;
    logic [DATA_W-1:0] output_data;
    logic              layer6_calculation_done;
    logic              read_pixel_signal;
    logic [ADDR_W-1:0] read_row_addr;
    logic [ADDR_W-1:0] read_col_addr;
    logic [DATA_W-1:0] read_data;
    logic              read_valid;
    logic              pixel_store_done;
    logic              frame_error;

    modport master (
        output save_enable, output_row, output_col, output_data, layer6_calculation_done,
        output read_pixel_signal, read_row_addr, read_col_addr,
        input  read_data, read_valid, pixel_store_done, frame_error
    );

    modport slave (
        input  save_enable, output_row, output_col, output_data, layer6_calculation_done,
        input  read_pixel_signal, read_row_addr, read_col_addr,
        output read_data, read_valid, pixel_store_done, frame_error
    );

endinterface

// File: rtl/buffer_mem.sv
// 1W1R synchronous frame RAM; read data registered, 1 cycle latency.
// Same-address read and write in one cycle returns the old contents; read register holds when idle.
module buffer_mem #(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 64,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdat,
    input  logic              i_re,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdat
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdat;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdat;
        end
        if (i_re) begin
            r_rdat <= r_mem[i_raddr];
        end
    end

    assign o_rdat = r_rdat;

endmodule

// File: rtl/layer6_result_buffer.sv
// Layer-6 pooled frame store: captures OUT_W x OUT_W pixels, pulses done, then serves reads.
// Read latency 1 cycle; no backpressure, writes and reads accepted every cycle.
// LAYER6_BUF_ZERO_PAD_EN: reads use 1-pixel zero-padded coordinates (3x3 conv halo).
module layer6_result_buffer
    import layer6_buf_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    layer6_result_buffer_if.slave  bus
);

    logic              w_wr_ok;
    logic [IDX_W-1:0]  w_wr_idx;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [ADDR_W-1:0] w_rd_row;
    logic [ADDR_W-1:0] w_rd_col;
    logic              w_rd_in;
    logic [IDX_W-1:0]  w_rd_idx;
    logic [DATA_W-1:0] w_mem_rdat;

    buf_state_t        r_state;
    logic [CNT_W-1:0]  r_wr_cnt;
    logic              r_rd_vld;
    logic              r_rd_zero;
    logic              r_done;
    logic              r_err;

    assign w_wr_ok   = bus.save_enable && in_frame(bus.output_row, bus.output_col);
    assign w_wr_idx  = pix_idx(bus.output_row, bus.output_col);
    assign w_cnt_nxt = r_wr_cnt + CNT_W'(w_wr_ok);

`ifdef LAYER6_BUF_ZERO_PAD_EN
    // Halo row/col 0 wraps to all-ones and fails the range check, so it reads as zero.
    assign w_rd_row = bus.read_row_addr - ADDR_W'(1);
    assign w_rd_col = bus.read_col_addr - ADDR_W'(1);
`else
    assign w_rd_row = bus.read_row_addr;
    assign w_rd_col = bus.read_col_addr;
`endif
    assign w_rd_in  = in_frame(w_rd_row, w_rd_col);
    assign w_rd_idx = pix_idx(w_rd_row, w_rd_col);

    buffer_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (FRAME_PIX),
        .AW     (IDX_W)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_wr_ok),
        .i_waddr (w_wr_idx),
        .i_wdat  (bus.output_data),
        .i_re    (bus.read_pixel_signal && w_rd_in),
        .i_raddr (w_rd_idx),
        .o_rdat  (w_mem_rdat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_wr_cnt  <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_rd_vld  <= 1'b0;
            r_rd_zero <= 1'b1;
        end else begin
            r_done   <= 1'b0;
            r_rd_vld <= bus.read_pixel_signal;
            // Zero flag masks the RAM output, so out-of-range reads need no RAM access.
            if (bus.read_pixel_signal) begin
                r_rd_zero <= !w_rd_in;
            end
            case (r_state)
                IDLE, SERVE: begin
                    if (bus.save_enable) begin
                        r_state  <= FILL;
                        r_wr_cnt <= CNT_W'(w_wr_ok);
                    end
                end
                FILL: begin
                    if (w_cnt_nxt == CNT_W'(FRAME_PIX)) begin
                        r_state  <= DONE;
                        r_wr_cnt <= '0;
                        r_done   <= 1'b1;
                    end else if (bus.layer6_calculation_done) begin
                        r_state  <= IDLE;
                        r_wr_cnt <= '0;
                        r_err    <= 1'b1;
                    end else begin
                        r_wr_cnt <= w_cnt_nxt;
                    end
                end
                DONE:    r_state <= SERVE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.read_data        = r_rd_zero ? '0 : w_mem_rdat;
    assign bus.read_valid       = r_rd_vld;
    assign bus.pixel_store_done = r_done;
    assign bus.frame_error      = r_err;

endmodule

// File: tb/tb_layer6_result_buffer.sv
// Scoreboard bench for layer6_result_buffer: randomized frames against a frame-level reference model.
module tb_layer6_result_buffer;
    import layer6_buf_pkg::*;

`ifdef LAYER6_BUF_ZERO_PAD_EN
    localparam int PAD = 1;
`else
    localparam int PAD = 0;
`endif

    typedef struct {
        int           cyc;
        logic [127:0] dat;
    } rd_exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    layer6_result_buffer_if bus();
    layer6_result_buffer dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_seen = 0;
    rd_exp_t rd_q[$];
    int done_q[$];

    logic [127:0] m_mem [8][8];
    bit m_filling = 0;
    int m_cnt = 0;
    bit m_err = 0;
    int m_frames = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [127:0] pix(input int r, input int c);
        logic [15:0] w;
        w = {r[7:0], c[7:0]};
        return {8{w}};
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [127:0] model_read(input int r, input int c);
        int pr, pc;
        pr = r - PAD;
        pc = c - PAD;
        if (pr >= 0 && pr < OUT_W && pc >= 0 && pc < OUT_W) return m_mem[pr][pc];
        return '0;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.save_enable = 0;
        bus.output_row = '0;
        bus.output_col = '0;
        bus.output_data = '0;
        bus.layer6_calculation_done = 0;
        bus.read_pixel_signal = 0;
        bus.read_row_addr = '0;
        bus.read_col_addr = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    // One cycle of stimulus; the model reads before it writes (old data on same-address collision).
    task automatic step(input bit we, input int wr, input int wc, input logic [127:0] wd,
                        input bit re, input int rr, input int rc, input bit cd);
        bit fin;
        fin = 0;
        if (re) rd_q.push_back('{cyc + 1, model_read(rr, rc)});
        bus.save_enable = we;
        bus.output_row = 16'(wr);
        bus.output_col = 16'(wc);
        bus.output_data = wd;
        bus.read_pixel_signal = re;
        bus.read_row_addr = 16'(rr);
        bus.read_col_addr = 16'(rc);
        bus.layer6_calculation_done = cd;
        if (we) begin
            if (!m_filling) begin
                m_filling = 1;
                m_cnt = 0;
            end
            if (wr < OUT_W && wc < OUT_W) begin
                m_mem[wr][wc] = wd;
                m_cnt++;
            end
        end
        if (m_filling) begin
            if (m_cnt == FRAME_PIX) begin
                done_q.push_back(cyc + 1);
                m_filling = 0;
                m_frames++;
                fin = 1;
            end else if (cd) begin
                m_err = 1;
                m_filling = 0;
            end
        end
        tick();
        if (fin) tick();
    endtask

    task automatic do_reset();
        tick();
        tick();
        rst = 1;
        m_filling = 0;
        m_cnt = 0;
        m_err = 0;
        tick();
        tick();
        rst = 0;
    endtask

    task automatic rand_frame(input bit with_oor);
        int perm[64];
        int j, t;
        for (int i = 0; i < 64; i++) perm[i] = i;
        for (int i = 63; i > 0; i--) begin
            j = $urandom_range(0, i);
            t = perm[i]; perm[i] = perm[j]; perm[j] = t;
        end
        for (int i = 0; i < 64; i++) begin
            if ($urandom_range(0, 3) == 0)
                step(0, 0, 0, '0, 1, $urandom_range(0, 10), $urandom_range(0, 10), 0);
            if (with_oor && $urandom_range(0, 7) == 0)
                step(1, $urandom_range(8, 40), $urandom_range(0, 9), rnd128(), 0, 0, 0, 0);
            step(1, perm[i] / 8, perm[i] % 8, rnd128(), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 10), $urandom_range(0, 10), i == 63);
        end
        for (int i = 0; i < 12; i++)
            step(0, 0, 0, '0, 1, $urandom_range(0, 10), $urandom_range(0, 10), 0);
    endtask

    // Monitor: pops expected reads and done pulses as the DUT presents them.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.pixel_store_done) begin
                done_seen++;
                checks++;
                if (done_q.size() == 0 || done_q[0] != cyc) begin
                    errors++;
                    $display("FAIL done_pulse: pulse at cycle %0d expected cycle %0d", cyc,
                             done_q.size() ? done_q[0] : -1);
                end
                if (done_q.size()) void'(done_q.pop_front());
            end else if (done_q.size() && done_q[0] <= cyc) begin
                checks++;
                errors++;
                $display("FAIL done_pulse: missing pulse expected at cycle %0d", done_q[0]);
                void'(done_q.pop_front());
            end
            if (bus.read_valid) begin
                checks++;
                if (rd_q.size() == 0 || rd_q[0].cyc != cyc) begin
                    errors++;
                    $display("FAIL read_valid: unexpected valid at cycle %0d", cyc);
                end else if (bus.read_data !== rd_q[0].dat) begin
                    errors++;
                    $display("FAIL read_data: got %h expected %h at cycle %0d",
                             bus.read_data, rd_q[0].dat, cyc);
                end
                if (rd_q.size()) void'(rd_q.pop_front());
            end else if (rd_q.size() && rd_q[0].cyc <= cyc) begin
                checks++;
                errors++;
                $display("FAIL read_valid: missing valid expected at cycle %0d", rd_q[0].cyc);
                void'(rd_q.pop_front());
            end
        end
    end

    initial begin
        logic [127:0] a_val;
        int k;
        idle_inputs();
        rst = 1;
        repeat (3) @(posedge clk);
        #1;
        rst = 0;
        chk("rst_read_valid", 128'(bus.read_valid), 128'(0));
        chk("rst_read_data", bus.read_data, '0);
        chk("rst_done", 128'(bus.pixel_store_done), 128'(0));
        chk("rst_frame_error", 128'(bus.frame_error), 128'(0));

        // Raster frame with an out-of-range write (and read) slipped in mid-frame.
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                if (r == 4 && c == 0) step(1, 8, 0, '1, 1, 8, 0, 0);
                step(1, r, c, pix(r, c), 0, 0, 0, 0);
            end
        step(0, 0, 0, '0, 1, 3, 5, 0);
`ifdef LAYER6_BUF_ZERO_PAD_EN
        chk("rd_3_5", bus.read_data, pix(2, 4));
`else
        chk("rd_3_5", bus.read_data, pix(3, 5));
`endif
        step(0, 0, 0, '0, 1, 8, 0, 0);
        step(0, 0, 0, '0, 1, 0, 4, 0);
        step(0, 0, 0, '0, 1, 1, 1, 0);
        step(0, 0, 0, '0, 1, 9, 9, 0);
        step(0, 0, 0, '0, 1, 3 + PAD, 6 + PAD, 0);

        // Collision read returns old pixel, then new one; frame then stops one short.
        a_val = rnd128();
        step(1, 2, 2, a_val, 1, 2 + PAD, 2 + PAD, 0);
        step(0, 0, 0, '0, 1, 2 + PAD, 2 + PAD, 0);
        chk("collision_new", bus.read_data, a_val);
        k = 0;
        for (int i = 0; i < 64 && k < 62; i++)
            if (i != 18) begin
                step(1, i / 8, i % 8, rnd128(), 0, 0, 0, 0);
                k++;
            end
        step(0, 0, 0, '0, 0, 0, 0, 1);
        chk("frame_error_set", 128'(bus.frame_error), 128'(m_err));
        repeat (3) step(0, 0, 0, '0, 1, $urandom_range(0, 10), $urandom_range(0, 10), 0);

        // Reset mid-frame, then a full random frame must give exactly one done pulse.
        for (int i = 0; i < 30; i++) step(1, i / 8, i % 8, rnd128(), 0, 0, 0, 0);
        do_reset();
        chk("rst2_frame_error", 128'(bus.frame_error), 128'(0));
        chk("rst2_read_data", bus.read_data, '0);
        chk("rst2_read_valid", 128'(bus.read_valid), 128'(0));
        rand_frame(0);
        rand_frame(1);

        // Incomplete random frame, then recovery with another full frame.
        for (int i = 0; i < 40; i++)
            step(1, $urandom_range(0, 7), $urandom_range(0, 7), rnd128(), 0, 0, 0, 0);
        step(0, 0, 0, '0, 1, 2, 2, 1);
        chk("frame_error_rand", 128'(bus.frame_error), 128'(m_err));
        rand_frame(1);

        repeat (4) tick();
        chk("done_count", 128'(done_seen), 128'(m_frames));
        chk("rd_q_empty", 128'(rd_q.size()), 128'(0));
        chk("done_q_empty", 128'(done_q.size()), 128'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
